// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: modulo-MODULUS up/down counter with a DIV prescaler,
// registered wrap pulse and combinational BCD digit breakout of the count.
`timescale 1ns/100ps
module bcd_updown_counter #(
    parameter int MODULUS = 60,
    parameter int DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       direction,
    output logic [5:0] count,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic       wrap
);

    // Prescaler is at least one bit wide so DIV=1 still has a legal vector.
    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PDIV_MAX = PW'(DIV - 1);
    localparam logic [5:0]     CNT_MAX  = 6'(MODULUS - 1);

    logic [PW-1:0] pdiv;
    logic          tick;
    logic [5:0]    count_nxt;
    logic          wrap_nxt;

    // A tick happens on the enabled edge that closes a prescaler period.
    assign tick = enable && (pdiv == PDIV_MAX);

    // Prescaler phase: advances only on enabled edges, so phase survives disables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pdiv <= '0;
        else if (enable)
            pdiv <= (pdiv == PDIV_MAX) ? '0 : pdiv + 1'b1;
    end

    // Next count and wrap flag; out-of-range counts recover to 0 silently.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (tick) begin
            if (count > CNT_MAX) begin
                count_nxt = '0;
            end else if (direction) begin
                if (count == CNT_MAX) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 6'd1;
                end
            end else begin
                if (count == '0) begin
                    count_nxt = CNT_MAX;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 6'd1;
                end
            end
        end
    end

    // Count and wrap registers update together so wrap marks its own edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Decimal split of 0..63: pick the highest multiple of ten not above count.
    always_comb begin
        logic [5:0] rem;
        rem      = count;
        bcd_tens = 4'd0;
        for (int t = 1; t <= 6; t++) begin
            if (count >= 6'(t * 10)) begin
                bcd_tens = 4'(t);
                rem      = count - 6'(t * 10);
            end
        end
        bcd_ones = rem[3:0];
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: default 0..59 instance, a DIV=4
// instance and a MODULUS=10 instance, all on one 2-unit clock.
`timescale 1ns/100ps
module tb_bcd_updown_counter;

    logic clk;
    logic rst, en, dir;
    logic rst4, en4, dir4;
    logic rst10, en10, dir10;

    logic [5:0] cnt, cnt4, cnt10;
    logic [3:0] ones, tens, ones4, tens4, ones10, tens10;
    logic       wrp, wrp4, wrp10;

    int n_cmp = 0;
    int n_err = 0;

    bcd_updown_counter #(.MODULUS(60), .DIV(1)) u_d0 (
        .clk(clk), .rst(rst), .enable(en), .direction(dir),
        .count(cnt), .bcd_ones(ones), .bcd_tens(tens), .wrap(wrp)
    );

    bcd_updown_counter #(.MODULUS(60), .DIV(4)) u_d4 (
        .clk(clk), .rst(rst4), .enable(en4), .direction(dir4),
        .count(cnt4), .bcd_ones(ones4), .bcd_tens(tens4), .wrap(wrp4)
    );

    bcd_updown_counter #(.MODULUS(10), .DIV(1)) u_d10 (
        .clk(clk), .rst(rst10), .enable(en10), .direction(dir10),
        .count(cnt10), .bcd_ones(ones10), .bcd_tens(tens10), .wrap(wrp10)
    );

    // rising edges at odd times
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst = 0; en = 0; dir = 1;
        rst4 = 0; en4 = 0; dir4 = 1;
        rst10 = 0; en10 = 0; dir10 = 1;

        // reset state
        #4;
        chk("rst_cnt", cnt, 0);
        chk("rst_wrap", wrp, 0);
        chk("rst_ones", ones, 0);
        chk("rst_tens", tens, 0);
        #6 rst = 1;                          // t=10
        #10 en = 1;                          // t=20
        #10;                                 // t=30: 5 edges
        chk("up5_cnt", cnt, 5);
        chk("up5_ones", ones, 5);
        chk("up5_tens", tens, 0);
        en = 0;
        #10;                                 // t=40
        chk("hold_cnt", cnt, 5);
        chk("hold_wrap", wrp, 0);
        en = 1;
        #10;                                 // t=50
        chk("up10_cnt", cnt, 10);
        chk("up10_tens", tens, 1);
        chk("up10_ones", ones, 0);
        dir = 0;
        #10;                                 // t=60
        chk("dn5_cnt", cnt, 5);
        dir = 1;

        // up wrap: 54 edges to reach 59
        #108;                                // t=168
        chk("at59_cnt", cnt, 59);
        chk("at59_tens", tens, 5);
        chk("at59_ones", ones, 9);
        chk("at59_wrap", wrp, 0);
        #2;                                  // t=170
        chk("upwrap_cnt", cnt, 0);
        chk("upwrap_wrap", wrp, 1);
        #2;                                  // t=172
        chk("postwrap_cnt", cnt, 1);
        chk("postwrap_wrap", wrp, 0);

        // async reset at 37 (36 more edges)
        #72;                                 // t=244
        chk("at37_cnt", cnt, 37);
        chk("at37_tens", tens, 3);
        chk("at37_ones", ones, 7);
        rst = 0;
        #0.5;
        chk("arst_cnt", cnt, 0);
        chk("arst_ones", ones, 0);
        chk("arst_tens", tens, 0);
        #3.5;                                // t=248, two enabled edges under reset
        chk("arst_hold", cnt, 0);
        chk("arst_wrap", wrp, 0);

        // down wrap from 0
        dir = 0;
        rst = 1;
        #2;                                  // t=250
        chk("dnwrap_cnt", cnt, 59);
        chk("dnwrap_tens", tens, 5);
        chk("dnwrap_ones", ones, 9);
        chk("dnwrap_wrap", wrp, 1);
        en = 0;
        #2;                                  // t=252
        chk("dnwrap_pulse", wrp, 0);
        chk("dnwrap_held", cnt, 59);

        // prescaler DIV=4
        rst4 = 1; en4 = 1;
        #6;                                  // t=258: 3 edges
        chk("div_3e", cnt4, 0);
        #2;                                  // t=260: 4 edges
        chk("div_4e", cnt4, 1);
        #16;                                 // t=276: 12 edges
        chk("div_12e", cnt4, 3);
        #4 en4 = 0;                          // t=280: phase 2 of 4
        #4;                                  // t=284: 2 disabled edges
        chk("div_dis", cnt4, 3);
        en4 = 1;
        #2;                                  // t=286: phase 3
        chk("div_phase", cnt4, 3);
        #2;                                  // t=288: tick
        chk("div_resume", cnt4, 4);
        chk("div_wrap", wrp4, 0);

        // MODULUS=10 sweeps
        rst10 = 1; en10 = 1; dir10 = 1;
        for (int k = 1; k <= 10; k++) begin
            #2;
            chk("m10_up_cnt", cnt10, k % 10);
            chk("m10_up_tens", tens10, 0);
            chk("m10_up_wrap", wrp10, (k == 10) ? 1 : 0);
        end
        dir10 = 0;
        for (int k = 1; k <= 10; k++) begin
            #2;
            chk("m10_dn_cnt", cnt10, (10 - k) % 10);
            chk("m10_dn_tens", tens10, 0);
            chk("m10_dn_wrap", wrp10, (k == 1) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
